imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/pat_pkg.sv | 16 +
 rtl/imem_line_packer.sv | 55 +++++
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// Shared widths and loader FSM states for the PAT core.
// Imported by the instruction-memory loader and its line packer.
package pat_pkg;

  localparam int DEF_I_ADR_WIDTH   = 10;
  localparam int DEF_I_WIDTH       = 20;
  localparam int DEF_I_BUFFER_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_line_packer.sv
// Packs accepted instructions into buffer lines, lane by lane.
// Flags a finished line on the last lane or the final instruction.
module imem_line_packer
  import pat_pkg::*;
#(
  parameter int I_WIDTH       = DEF_I_WIDTH,
  parameter int I_BUFFER_SIZE = DEF_I_BUFFER_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             accept,
  input  logic                             last,
  input  logic [I_WIDTH-1:0]               data,
  output logic [I_BUFFER_SIZE*I_WIDTH-1:0] line,
  output logic                             line_done
);

  localparam int LW =
    (I_BUFFER_SIZE > 1) ? $clog2(I_BUFFER_SIZE) : 1;
  localparam int LINE_W = I_BUFFER_SIZE * I_WIDTH;
  localparam logic [LW-1:0] LAST_LANE =
    LW'(I_BUFFER_SIZE - 1);

  logic [LW-1:0]     lane;
  logic [LINE_W-1:0] buf_q;

  // merge the incoming instruction into its lane of the open line
  always_comb begin
    line = buf_q;
    for (int j = 0; j < I_BUFFER_SIZE; j++) begin
      if (accept && lane == LW'(j)) begin
        line[j*I_WIDTH +: I_WIDTH] = data;
      end
    end
  end

  assign line_done = accept && (lane == LAST_LANE || last);

  // a completed line restarts from an all-zero buffer so
  // lanes never filled in a short final line read as zero
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane  <= '0;
      buf_q <= '0;
    end else if (line_done) begin
      lane  <= '0;
      buf_q <= '0;
    end else if (accept) begin
      lane  <= lane + LW'(1);
      buf_q <= line;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams host instructions into the instruction buffer, line by line,
// holding the PAT core in reset until the program is loaded.
module imem_loader
  import pat_pkg::*;
#(
  parameter int I_ADR_WIDTH   = DEF_I_ADR_WIDTH,
  parameter int I_WIDTH       = DEF_I_WIDTH,
  parameter int I_BUFFER_SIZE = DEF_I_BUFFER_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_start,
  input  logic [I_ADR_WIDTH-1:0]           load_base,
  input  logic [I_ADR_WIDTH:0]             load_count,
  input  logic                             in_valid,
  input  logic [I_WIDTH-1:0]               in_data,
  output logic                             in_ready,
  output logic [I_ADR_WIDTH-1:0]           imem_write_adr,
  output logic                             imem_write,
  output logic [I_BUFFER_SIZE*I_WIDTH-1:0] imem_in,
  output logic                             core_reset,
  output logic                             busy,
  output logic                             done
);

  localparam int AW     = I_ADR_WIDTH;
  localparam int LINE_W = I_BUFFER_SIZE * I_WIDTH;

  state_t state, state_nxt;

  logic [AW:0]       cnt_q;
  logic [AW:0]       acc_q;
  logic [AW:0]       acc_inc;
  logic [AW-1:0]     line_adr;
  logic              accept;
  logic              last;
  logic              start_load;
  logic              zero_load;
  logic [LINE_W-1:0] line;
  logic              line_done;

  assign accept  = in_valid && in_ready;
  assign acc_inc = acc_q + (AW+1)'(1);
  assign last    = accept && (acc_inc == cnt_q);

  imem_line_packer #(
    .I_WIDTH       (I_WIDTH),
    .I_BUFFER_SIZE (I_BUFFER_SIZE)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load),
    .accept    (accept),
    .last      (last),
    .data      (in_data),
    .line      (line),
    .line_done (line_done)
  );

  // next state; a start is honoured only from IDLE or RUN
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    zero_load  = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (load_start) begin
          if (load_count != '0) begin
            state_nxt  = LOAD;
            start_load = 1'b1;
          end else begin
            state_nxt = RUN;
            zero_load = 1'b1;
          end
        end
      end
      LOAD: begin
        if (last) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // state, load bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      line_adr       <= '0;
      in_ready       <= 1'b0;
      imem_write     <= 1'b0;
      imem_write_adr <= '0;
      imem_in        <= '0;
      core_reset     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_load) begin
        cnt_q    <= load_count;
        acc_q    <= '0;
        line_adr <= load_base;
      end else begin
        if (accept) acc_q <= acc_inc;
        if (line_done) line_adr <= line_adr + AW'(1);
      end
      imem_write <= line_done;
      if (line_done) begin
        imem_in        <= line;
        imem_write_adr <= line_adr;
      end
      in_ready   <= (state_nxt == LOAD);
      busy       <= (state_nxt == LOAD) ||
                    (state_nxt == FLUSH);
      core_reset <= (state_nxt != RUN);
      done       <= (state == FLUSH) || zero_load;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Expected line writes are queued at stimulus time and popped on writes.
module tb_imem_loader;

  localparam int AW = 10;
  localparam int IW = 20;
  localparam int NB = 2;
  localparam int LW = NB * IW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_count = '0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] imem_write_adr;
  logic          imem_write;
  logic [LW-1:0] imem_in;
  logic          core_reset;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;

  logic [AW+LW-1:0] sb[$];

  imem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .load_base      (load_base),
    .load_count     (load_count),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .imem_write_adr (imem_write_adr),
    .imem_write     (imem_write),
    .imem_in        (imem_in),
    .core_reset     (core_reset),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // write monitor: every line write must match the queue head
  always @(negedge clk) begin
    if (imem_write === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("extra_wr", {54'd0, imem_write_adr}, 64'h3ff_ffff);
      end else begin
        logic [AW+LW-1:0] e;
        e = sb.pop_front();
        chk("wr_adr", 64'(imem_write_adr), 64'(e[AW+LW-1:LW]));
        chk("wr_data", 64'(imem_in), 64'(e[LW-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lines(input int base, input int cnt,
                            input int d0);
    int nl;
    nl = (cnt + NB - 1) / NB;
    for (int l = 0; l < nl; l++) begin
      logic [LW-1:0] ln;
      logic [AW-1:0] a;
      ln = '0;
      for (int j = 0; j < NB; j++) begin
        int k;
        k = l * NB + j;
        if (k < cnt) ln[j*IW +: IW] = IW'(d0 + k);
      end
      a = AW'((base + l) % (1 << AW));
      sb.push_back({a, ln});
    end
  endtask

  task automatic do_load(input int base, input int cnt,
                         input int d0, input bit toggle,
                         input bit poke, input int exp_cyc);
    int k;
    int cyc;
    int w0;
    bit ph;
    bit acc;
    w0 = wr_cnt;
    push_lines(base, cnt, d0);
    load_start = 1'b1;
    load_base  = AW'(base);
    load_count = (AW+1)'(cnt);
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("ent_crst", 64'(core_reset), 64'd1);
    chk("ent_busy", 64'(busy), 64'd1);
    chk("ent_rdy", 64'(in_ready), 64'd1);
    k = 0;
    cyc = 0;
    ph = 1'b1;
    while (k < cnt && cyc < 100) begin
      in_valid = toggle ? ph : 1'b1;
      in_data  = IW'(d0 + k);
      if (poke && cyc == 1) begin
        load_start = 1'b1;
        load_base  = AW'(base + 7);
        load_count = (AW+1)'(1);
      end
      acc = in_valid && in_ready;
      tick();
      load_start = 1'b0;
      if (acc) k++;
      ph = ~ph;
      cyc++;
    end
    in_valid = 1'b0;
    chk("cycles", 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    chk("fl_busy", 64'(busy), 64'd1);
    chk("fl_rdy", 64'(in_ready), 64'd0);
    chk("fl_done", 64'(done), 64'd0);
    chk("fl_crst", 64'(core_reset), 64'd1);
    tick();
    @(negedge clk);
    chk("run_done", 64'(done), 64'd1);
    chk("run_crst", 64'(core_reset), 64'd0);
    chk("run_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("wr_num", 64'(wr_cnt - w0),
        64'((cnt + NB - 1) / NB));
  endtask

  task automatic zero_load();
    int w0;
    w0 = wr_cnt;
    load_start = 1'b1;
    load_count = '0;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("z_done", 64'(done), 64'd1);
    chk("z_crst", 64'(core_reset), 64'd0);
    chk("z_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    chk("z_pulse", 64'(done), 64'd0);
    chk("z_wr", 64'(wr_cnt - w0), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_crst", 64'(core_reset), 64'd1);
    chk("rst_wr", 64'(imem_write), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_adr", 64'(imem_write_adr), 64'd0);
    chk("rst_in", 64'(imem_in), 64'd0);
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("idle_rdy", 64'(in_ready), 64'd0);
    chk("idle_crst", 64'(core_reset), 64'd1);
    in_valid = 1'b0;
    tick();

    zero_load();
    do_load(5, 4, 1, 1'b0, 1'b0, 4);
    do_load(0, 3, 1, 1'b0, 1'b0, 3);
    do_load(1023, 4, 'h100, 1'b0, 1'b0, 4);
    do_load(5, 4, 1, 1'b1, 1'b0, 7);
    do_load(10, 2, 'h50, 1'b0, 1'b1, 2);

    // abort a load after one accept
    load_start = 1'b1;
    load_base  = AW'(0);
    load_count = (AW+1)'(4);
    tick();
    load_start = 1'b0;
    in_valid = 1'b1;
    in_data  = IW'('hA);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("ab_crst", 64'(core_reset), 64'd1);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_rdy", 64'(in_ready), 64'd0);
    chk("ab_wr", 64'(imem_write), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("ab_idle", 64'(in_ready), 64'd0);
    chk("ab_sb", 64'(sb.size()), 64'd0);
    tick();
    do_load(0, 2, 'h11, 1'b0, 1'b0, 2);
    zero_load();

    repeat (3) tick();
    chk("end_sb", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
